// File: rtl/placement_verifier_if.sv
// Control, result and memory-port bundle for the placement verifier.
// Latency: none (wiring only).
// Backpressure: none; memory ports are fixed-latency registered ROMs.
//
// master: the verifier (drives strobes, addresses and results).
// slave : the environment (drives start and the ROM read data).
interface placement_verifier_if;
   logic               start;
   logic               busy;
   logic               done;
   logic [1:0]         error_code;
   logic signed [31:0] cost;
   logic               grid_re;
   logic [31:0]        grid_addr;
   logic signed [31:0] grid_data;
   logic               ea_re;
   logic               eb_re;
   logic [31:0]        ea_addr;
   logic [31:0]        eb_addr;
   logic signed [31:0] ea_data;
   logic signed [31:0] eb_data;

   modport master (
      input  start, grid_data, ea_data, eb_data,
      output busy, done, error_code, cost,
             grid_re, grid_addr, ea_re, eb_re, ea_addr, eb_addr
   );

   modport slave (
      output start, grid_data, ea_data, eb_data,
      input  busy, done, error_code, cost,
             grid_re, grid_addr, ea_re, eb_re, ea_addr, eb_addr
   );
endinterface

// File: rtl/placement_verifier.sv
// Re-reads a finished placement grid, rebuilds node X/Y, recomputes wirelength.
// Latency: done is high 3*N*N + 3*N_EDGE + 1 cycles after start is sampled.
// Backpressure: none; start is ignored while busy, ROM reads are fixed latency.
//
// Ports: clk, reset (sync, active-high) plus bus (master modport):
//   start/busy/done handshake, error_code + cost results,
//   grid_re/grid_addr/grid_data grid ROM, ea_*/eb_* edge endpoint ROMs.
module placement_verifier #(
   parameter int N       = 4,
   parameter int N_NODES = 16,
   parameter int N_EDGE  = 15
) (
   input logic                  clk,
   input logic                  reset,
   placement_verifier_if.master bus
);

   localparam int CW    = (N > 1) ? $clog2(N) : 1;
   localparam int IW    = (N_NODES > 1) ? $clog2(N_NODES) : 1;
   localparam int NCELL = N * N;
   localparam logic [CW-1:0] YMAX      = CW'(N - 1);
   localparam logic [31:0]   LAST_CELL = 32'(NCELL - 1);
   localparam logic [31:0]   LAST_EDGE = 32'(N_EDGE - 1);

   typedef enum logic [2:0] {
      IDLE, SCAN_REQ, SCAN_WAIT, SCAN_CHK,
      EDGE_REQ, EDGE_WAIT, EDGE_EVAL, DONE
   } state_t;

   state_t               state;
   logic [31:0]          cell_cnt;
   logic [31:0]          edge_cnt;
   logic [CW-1:0]        scan_x;
   logic [CW-1:0]        scan_y;
   logic [N_NODES-1:0]   node_vld;
   logic [CW-1:0]        node_x [N_NODES];
   logic [CW-1:0]        node_y [N_NODES];

   // Grid cell decode
   logic                 g_empty;
   logic                 g_in;
   logic [IW-1:0]        g_idx;

   // Edge endpoint decode and wirelength term
   logic                 a_in, b_in, a_ok, b_ok;
   logic [IW-1:0]        a_idx, b_idx;
   logic signed [31:0]   xa, ya, xb, yb, dx, dy, adx, ady, wl;

   always_comb begin
      g_empty = (bus.grid_data == -32'sd1);
      g_in    = (bus.grid_data >= 0) && (bus.grid_data < N_NODES);
      g_idx   = bus.grid_data[IW-1:0];

      a_in  = (bus.ea_data >= 0) && (bus.ea_data < N_NODES);
      b_in  = (bus.eb_data >= 0) && (bus.eb_data < N_NODES);
      a_idx = bus.ea_data[IW-1:0];
      b_idx = bus.eb_data[IW-1:0];
      // Short-circuit keeps the valid-bit lookup behind the range check.
      a_ok  = a_in && node_vld[a_idx];
      b_ok  = b_in && node_vld[b_idx];

      xa  = signed'({{(32-CW){1'b0}}, node_x[a_idx]});
      ya  = signed'({{(32-CW){1'b0}}, node_y[a_idx]});
      xb  = signed'({{(32-CW){1'b0}}, node_x[b_idx]});
      yb  = signed'({{(32-CW){1'b0}}, node_y[b_idx]});
      dx  = xa - xb;
      dy  = ya - yb;
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      // Adjacent cells count as zero wirelength, hence the -1.
      wl  = adx + ady - 32'sd1;
   end

   // Strobes, addresses and done are registered: each is set on the
   // transition into the state that owns it and cleared on the way out.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.error_code <= 2'd0;
         bus.cost       <= 32'sd0;
         bus.grid_re    <= 1'b0;
         bus.grid_addr  <= 32'd0;
         bus.ea_re      <= 1'b0;
         bus.eb_re      <= 1'b0;
         bus.ea_addr    <= 32'd0;
         bus.eb_addr    <= 32'd0;
         cell_cnt       <= 32'd0;
         edge_cnt       <= 32'd0;
         scan_x         <= '0;
         scan_y         <= '0;
         node_vld       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  node_vld       <= '0;
                  bus.cost       <= 32'sd0;
                  bus.error_code <= 2'd0;
                  cell_cnt       <= 32'd0;
                  edge_cnt       <= 32'd0;
                  scan_x         <= '0;
                  scan_y         <= '0;
                  bus.busy       <= 1'b1;
                  bus.grid_re    <= 1'b1;
                  bus.grid_addr  <= 32'd0;
                  state          <= SCAN_REQ;
               end
            end

            SCAN_REQ: begin
               bus.grid_re <= 1'b0;
               state       <= SCAN_WAIT;
            end

            SCAN_WAIT: begin
               state <= SCAN_CHK;
            end

            SCAN_CHK: begin
               if (g_empty) begin
                  // empty cell, nothing to record
               end else if (g_in) begin
                  if (node_vld[g_idx]) begin
                     // Duplicate: first position stays in the table.
                     if (bus.error_code == 2'd0) bus.error_code <= 2'd1;
                  end else begin
                     node_vld[g_idx] <= 1'b1;
                     node_x[g_idx]   <= scan_x;
                     node_y[g_idx]   <= scan_y;
                  end
               end else begin
                  if (bus.error_code == 2'd0) bus.error_code <= 2'd2;
               end

               if (cell_cnt == LAST_CELL) begin
                  if (N_EDGE == 0) begin
                     bus.done <= 1'b1;
                     state    <= DONE;
                  end else begin
                     edge_cnt    <= 32'd0;
                     bus.ea_re   <= 1'b1;
                     bus.eb_re   <= 1'b1;
                     bus.ea_addr <= 32'd0;
                     bus.eb_addr <= 32'd0;
                     state       <= EDGE_REQ;
                  end
               end else begin
                  cell_cnt      <= cell_cnt + 32'd1;
                  bus.grid_addr <= cell_cnt + 32'd1;
                  bus.grid_re   <= 1'b1;
                  // x-major walk: y is the fast index.
                  if (scan_y == YMAX) begin
                     scan_y <= '0;
                     scan_x <= scan_x + 1'b1;
                  end else begin
                     scan_y <= scan_y + 1'b1;
                  end
                  state <= SCAN_REQ;
               end
            end

            EDGE_REQ: begin
               bus.ea_re <= 1'b0;
               bus.eb_re <= 1'b0;
               state     <= EDGE_WAIT;
            end

            EDGE_WAIT: begin
               state <= EDGE_EVAL;
            end

            EDGE_EVAL: begin
               if (a_ok && b_ok) begin
                  bus.cost <= bus.cost + wl;
               end else if (bus.error_code == 2'd0) begin
                  bus.error_code <= 2'd3;
               end

               if (edge_cnt == LAST_EDGE) begin
                  bus.done <= 1'b1;
                  state    <= DONE;
               end else begin
                  edge_cnt    <= edge_cnt + 32'd1;
                  bus.ea_addr <= edge_cnt + 32'd1;
                  bus.eb_addr <= edge_cnt + 32'd1;
                  bus.ea_re   <= 1'b1;
                  bus.eb_re   <= 1'b1;
                  state       <= EDGE_REQ;
               end
            end

            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/placement_verifier.md
PLACEMENT_VERIFIER -- requirements
Module: placement_verifier

Interface
REQ-001 SHALL have parameter N, default 4: grid side; the grid has N*N cells at address x*N+y.
REQ-002 SHALL have parameter N_NODES, default 16: size of the node ID space, IDs 0..N_NODES-1.
REQ-003 SHALL have parameter N_EDGE, default 15: number of edges in the EA/EB lists.
REQ-004 SHALL have ports, each given as name, direction, width, meaning:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin a verification pass.
- busy  out  1  pass in progress.
- done  out  1  one-cycle completion pulse.
- error_code  out  2  0 = ok, 1 = duplicate node, 2 = cell value out of range, 3 = unplaced endpoint.
- cost  out  32 signed  wirelength sum.
- grid_re  out  1  grid read strobe.
- grid_addr  out  32  grid read address.
- grid_data  in  32 signed  grid cell value; -1 = empty.
- ea_re, eb_re  out  1  edge-list read strobes.
- ea_addr, eb_addr  out  32  edge index.
- ea_data, eb_data  in  32 signed  edge endpoint node IDs.
REQ-005 SHALL treat every memory port as a registered ROM: data is valid in the cycle after the strobe and holds until the next strobe.

Function
REQ-006 SHALL read back a finished placement grid, rebuild the per-node X/Y table, and recompute the wirelength over the edge lists.
REQ-007 SHALL implement states IDLE, SCAN_REQ, SCAN_WAIT, SCAN_CHK, EDGE_REQ, EDGE_WAIT, EDGE_EVAL, DONE.
REQ-008 SHALL accept start only in IDLE, and ignore start in every other state.
REQ-009 On accepted start, SHALL clear the node table valid bits, set cost to 0 and error_code to 0, set cell and edge counters to 0, and go to SCAN_REQ.
REQ-010 In SCAN_REQ, SHALL assert grid_re for one cycle with grid_addr = cell counter; cells are scanned x-major, x = cnt/N, y = cnt%N.
REQ-011 In SCAN_WAIT, SHALL perform no action.
REQ-012 In SCAN_CHK, SHALL act on grid_data as follows:
- -1: skip the cell.
- In 0..N_NODES-1 with valid already set: record error 1, keep the first position.
- In 0..N_NODES-1, otherwise: store X = x, Y = y and set valid.
- Any other value: record error 2.
REQ-013 After the last cell (cnt = N*N-1), SCAN_CHK SHALL go to EDGE_REQ; otherwise it SHALL increment the counter and return to SCAN_REQ.
REQ-014 In EDGE_REQ, SHALL assert ea_re and eb_re together with address = edge counter.
REQ-015 In EDGE_WAIT, SHALL perform no action.
REQ-016 In EDGE_EVAL, if both endpoints are in range and valid, SHALL add |Xa-Xb| + |Ya-Yb| - 1 to cost, using 32-bit signed arithmetic with no saturation.
REQ-017 In EDGE_EVAL, if either endpoint is not in range and valid, SHALL record error 3 and leave cost unchanged.
REQ-018 After edge N_EDGE-1, EDGE_EVAL SHALL go to DONE; otherwise it SHALL increment the edge counter and return to EDGE_REQ.
REQ-019 A recorded error SHALL be sticky: only the first error code of a pass is kept, and the pass continues to completion.
REQ-020 In DONE, SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 SHALL hold cost and error_code from DONE until the next accepted start.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 Latency: done SHALL be high exactly 3*N*N + 3*N_EDGE + 1 cycles after the cycle in which start is sampled; with defaults this is 94 cycles.
REQ-024 Strobes grid_re, ea_re and eb_re SHALL be high only in their REQ states.
REQ-025 Addresses SHALL hold their last value when their strobe is low.
REQ-026 When N_EDGE = 0, SHALL go directly from the scan phase to DONE with cost = 0.

Reset
REQ-027 On reset, SHALL drive state to IDLE and set busy, done, all strobes, all addresses, cost and error_code to 0, and clear every node valid bit.
REQ-028 Reset mid-pass SHALL abort the pass with no done pulse, and the next start SHALL run a full, correct pass.
REQ-029 Reset SHALL take priority over start in the same cycle.

Verification
REQ-030 All cells -1 and every edge (0,1), start -> error_code = 3, cost = 0, done exactly 94 cycles after start.
REQ-031 Node 0 at addr 0 and node 1 at addr 15, all 15 edges (0,1) -> cost = 75, error_code = 0.
REQ-032 Node 2 at addr 1 and again at addr 5, plus a valid edge (0,2) with node 0 at addr 0 -> error_code = 1, and that edge contributes |0-0| + |0-1| - 1 = 0.
REQ-033 A cell value of 20 at addr 3, all else valid -> error_code = 2, pass completes, done pulses once.
REQ-034 Reset asserted 30 cycles after start -> busy = 0 the next cycle and no done pulse; a new start then gives done at +94 with correct cost.
REQ-035 start pulsed again at +10 and +50 during a pass -> ignored, a single done at +94, and the scan order is unchanged.
